// File: rtl/serial_full_adder_if.sv
// serial_full_adder_if
//   Operand/result channel of the serial adder.
//   Operand side : in_valid/in_ready handshake carrying a, b, cin, sub.
//   Result side  : out_valid/out_ready handshake carrying sum, cout, ovf.
//   master : the producer/consumer attached to the adder.
//   slave  : the adder itself.
`timescale 1ns/1ps

interface serial_full_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_full_adder.sv
// serial_full_adder
//   Multi-cycle adder/subtractor. Two WIDTH-bit operands are consumed
//   BITS_PER_CYCLE bits per clock through a ripple chain of full-adder cells;
//   the carry is registered between slices. Result appears N = WIDTH /
//   BITS_PER_CYCLE edges after the operand is accepted and is held until the
//   consumer takes it.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (aborts any operation in flight)
//     bus    serial_full_adder_if.slave
//              in_valid/in_ready, a, b, cin, sub   operand channel
//              out_valid/out_ready, sum, cout, ovf result channel
//            sub=0: {cout,sum} = a + b + cin
//            sub=1: {cout,sum} = a + ~b + 1  (cout=1 means no borrow)
//            ovf is two's-complement overflow in both modes.
`timescale 1ns/1ps

module serial_full_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_full_adder_if.slave    bus
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("serial_full_adder: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   load;
  logic   step;
  logic   last;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;    // already inverted for subtraction
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;

  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic [BITS_PER_CYCLE:0]   c;  // c[i] is the carry into cell i

  // Ripple chain of full-adder cells over the low slice of the operands.
  always_comb begin
    slice_sum = '0;
    c         = '0;
    c[0]      = carry;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_sum[i] = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]       = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
  end

  assign last = (cnt == CW'(N - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // No accept on the release edge: in_ready only rises once back in IDLE.
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers are all reset as well (not just the FSM), so
  // an aborted operation leaves no partial sum or stale flags on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;   // subtraction forces the +1 of two's complement
    end else if (step) begin
      a_sh  <= a_sh >> BITS_PER_CYCLE;
      b_sh  <= b_sh >> BITS_PER_CYCLE;
      carry <= c[BITS_PER_CYCLE];
      // New slice enters at the MSB end; after N slices slice 0 sits at bit 0.
      res   <= (res >> BITS_PER_CYCLE) |
               (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_r <= c[BITS_PER_CYCLE];
        // The operand MSB is the top cell of the final slice.
        ovf_r  <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = res;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder
//   Directed bench for serial_full_adder. Two instances share clk/rst_n:
//   u_dut1 (WIDTH=8, BITS_PER_CYCLE=1) and u_dut4 (WIDTH=8, BITS_PER_CYCLE=4).
//   'sel' chooses which instance the shared driver and monitor signals talk to.
`timescale 1ns/1ps

module tb_serial_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 1;

  logic       drv_in_valid;
  logic       drv_out_ready;
  logic       drv_cin;
  logic       drv_sub;
  logic [7:0] drv_a;
  logic [7:0] drv_b;

  serial_full_adder_if #(.WIDTH(8)) bus1 ();
  serial_full_adder_if #(.WIDTH(8)) bus4 ();

  assign bus1.in_valid  = drv_in_valid  && (sel == 1);
  assign bus1.out_ready = drv_out_ready && (sel == 1);
  assign bus1.a         = drv_a;
  assign bus1.b         = drv_b;
  assign bus1.cin       = drv_cin;
  assign bus1.sub       = drv_sub;

  assign bus4.in_valid  = drv_in_valid  && (sel == 4);
  assign bus4.out_ready = drv_out_ready && (sel == 4);
  assign bus4.a         = drv_a;
  assign bus4.b         = drv_b;
  assign bus4.cin       = drv_cin;
  assign bus4.sub       = drv_sub;

  serial_full_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  serial_full_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  logic       m_in_ready;
  logic       m_out_valid;
  logic       m_cout;
  logic       m_ovf;
  logic [7:0] m_sum;

  assign m_in_ready  = (sel == 4) ? bus4.in_ready  : bus1.in_ready;
  assign m_out_valid = (sel == 4) ? bus4.out_valid : bus1.out_valid;
  assign m_sum       = (sel == 4) ? bus4.sum       : bus1.sum;
  assign m_cout      = (sel == 4) ? bus4.cout      : bus1.cout;
  assign m_ovf       = (sel == 4) ? bus4.ovf       : bus1.ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, check result, optionally
  // stall the consumer while a spurious in_valid is offered, then release.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input int elat, input int stall, input string tag);
    int   lat;
    logic busy_ok;
    logic stable_ok;
    sel           = s;
    drv_a         = a;
    drv_b         = b;
    drv_cin       = ci;
    drv_sub       = sb;
    drv_out_ready = 1'b0;
    drv_in_valid  = 1'b1;
    check({tag, " in_ready before accept"}, m_in_ready, 1);
    tick();
    // Operands change after the accepting edge; the result must not follow.
    drv_in_valid = 1'b0;
    drv_a        = ~a;
    drv_b        = ~b;
    drv_cin      = ~ci;
    drv_sub      = ~sb;
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < 32) begin
      if (m_in_ready) busy_ok = 1'b0;
      if (m_out_valid) break;
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " in_ready low while busy"}, busy_ok, 1);
    check({tag, " sum"}, m_sum, es);
    check({tag, " cout"}, m_cout, ec);
    check({tag, " ovf"}, m_ovf, eo);
    if (stall > 0) begin
      stable_ok    = 1'b1;
      drv_in_valid = 1'b1;
      drv_a        = 8'h11;
      drv_b        = 8'h22;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_sum !== es ||
            m_cout !== ec || m_ovf !== eo)
          stable_ok = 1'b0;
      end
      check({tag, " stable during stall"}, stable_ok, 1);
      drv_in_valid = 1'b0;
    end
    drv_out_ready = 1'b1;
    tick();
    drv_out_ready = 1'b0;
    check({tag, " out_valid after release"}, m_out_valid, 0);
    check({tag, " in_ready after release"}, m_in_ready, 1);
    if (stall > 0) begin
      tick();
      check({tag, " no op from stall pulse"}, {m_in_ready, m_out_valid}, 2'b10);
    end
  endtask

  initial begin : stim
    int   accepts[$];
    logic quiet_ok;

    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    drv_cin       = 1'b0;
    drv_sub       = 1'b0;
    drv_a         = '0;
    drv_b         = '0;
    rst_n         = 1'b1;
    #1 rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", m_in_ready, 1);
    check("reset out_valid", m_out_valid, 0);
    check("reset sum", m_sum, 0);
    check("reset cout", m_cout, 0);
    check("reset ovf", m_ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // BITS_PER_CYCLE = 1, latency 8
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8, 0, "add ff+01");
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8, 0, "add 7f+01");
    run_op(1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8, 0, "add 80+80");
    run_op(1, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8, 0, "sub 05-07");
    run_op(1, 8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8, 0, "sub 33-33");
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8, 0, "sub 80-01");

    // Abort mid-RUN: previous op left cout=1/ovf=1, partial sum is nonzero.
    sel          = 1;
    drv_a        = 8'h3C;
    drv_b        = 8'h0F;
    drv_cin      = 1'b0;
    drv_sub      = 1'b0;
    drv_in_valid = 1'b1;
    tick();
    drv_in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort in_ready", m_in_ready, 1);
    check("abort out_valid", m_out_valid, 0);
    check("abort sum", m_sum, 0);
    check("abort cout", m_cout, 0);
    check("abort ovf", m_ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) quiet_ok = 1'b0;
    end
    check("abort no result presented", quiet_ok, 1);
    run_op(1, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 8, 0, "post-abort 10+20");

    // BITS_PER_CYCLE = 4, latency 2, with a 5-cycle consumer stall
    run_op(4, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2, 5, "bpc4 a5+5a+1");

    // Back-to-back: in_valid and out_ready held high, accepts every N+2 edges.
    sel           = 4;
    drv_a         = 8'h12;
    drv_b         = 8'h34;
    drv_cin       = 1'b0;
    drv_sub       = 1'b0;
    drv_in_valid  = 1'b1;
    drv_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (m_in_ready) accepts.push_back(i);
      tick();
    end
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    check("b2b accept count", accepts.size(), 3);
    if (accepts.size() >= 3) begin
      check("b2b interval 1", accepts[1] - accepts[0], 4);
      check("b2b interval 2", accepts[2] - accepts[1], 4);
    end
    check("b2b sum", m_sum, 8'h46);
    check("b2b cout", m_cout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
